// File: rtl/approx_mult_pkg.sv
// Shared types and helpers for the pipelined approximate multiplier.
package approx_mult_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned PP_W    = 2 * DIGIT_W;

    typedef enum logic [1:0] {
        MODE_EXACT         = 2'd0,
        MODE_LSQ_EXACT     = 2'd1,
        MODE_APPROX        = 2'd2,
        MODE_LOWSIG_APPROX = 2'd3
    } mode_e;

    // Decides whether partial product (i,j) of a P-digit operand pair is approximated.
    function automatic logic is_approx(input mode_e mode, input int unsigned i,
                                       input int unsigned j, input int unsigned p);
        logic        res;
        int unsigned s;
        s = i + j;
        case (mode)
            MODE_EXACT:         res = 1'b0;
            MODE_LSQ_EXACT:     res = (s != 0);
            MODE_APPROX:        res = 1'b1;
            MODE_LOWSIG_APPROX: res = (s < p / 2);
            default:            res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/approx_mult_pipe_mul4x4.sv
// Combinational 4x4 digit multiplier; approximate form clears the low PP_TRUNC bits.
module approx_mul4x4
    import approx_mult_pkg::*;
#(
    parameter int unsigned PP_TRUNC = 2
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               approx,
    output logic [PP_W-1:0]    p_c
);

    localparam logic [PP_W-1:0] TRUNC_MASK = PP_W'((16'd1 << PP_TRUNC) - 16'd1);

    logic [PP_W-1:0] prod;

    assign prod = PP_W'(a) * PP_W'(b);
    assign p_c  = approx ? (prod & ~TRUNC_MASK) : prod;

endmodule

// File: rtl/approx_mult_pipe.sv
// Three-stage valid/ready approximate multiplier built from 4x4 digit partial products.
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PP_TRUNC = 2,
    parameter int unsigned LOA_BITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] r,
    output logic [1:0]         r_mode
);

    localparam int unsigned P     = WIDTH / DIGIT_W;
    localparam int unsigned NPP   = P * P;
    localparam int unsigned RW    = 2 * WIDTH;
    localparam int unsigned IDX_W = $clog2(NPP);
    localparam logic [RW-1:0] LO_MASK = RW'((65'd1 << LOA_BITS) - 65'd1);

    logic                       en;
    logic                       s1_valid;
    logic [WIDTH-1:0]           s1_a;
    logic [WIDTH-1:0]           s1_b;
    mode_e                      s1_mode;
    logic                       s2_valid;
    mode_e                      s2_mode;
    logic [NPP-1:0][PP_W-1:0]   pp_c;
    logic [NPP-1:0][PP_W-1:0]   s2_pp;
    logic [NPP-1:0][RW-1:0]     aligned_c;
    logic [RW-1:0]              sum_exact_c;
    logic [RW-1:0]              sum_hi_c;
    logic [RW-1:0]              sum_lo_c;
    logic [RW-1:0]              sum_c;

    // Whole pipeline advances together; only a held output blocks it.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    for (genvar gi = 0; gi < P; gi++) begin : g_row
        for (genvar gj = 0; gj < P; gj++) begin : g_col
            approx_mul4x4 #(.PP_TRUNC(PP_TRUNC)) u_mul (
                .a      (s1_a[gi*DIGIT_W +: DIGIT_W]),
                .b      (s1_b[gj*DIGIT_W +: DIGIT_W]),
                .approx (is_approx(s1_mode, gi, gj, P)),
                .p_c    (pp_c[gi*P+gj])
            );
            assign aligned_c[gi*P+gj] = RW'(s2_pp[gi*P+gj]) << (DIGIT_W * (gi + gj));
        end
    end

    // Exact sum plus the lower-part-OR form: OR below LOA_BITS, carry-free add above.
    always_comb begin
        sum_exact_c = '0;
        sum_hi_c    = '0;
        sum_lo_c    = '0;
        for (int unsigned k = 0; k < NPP; k++) begin
            sum_exact_c = sum_exact_c + aligned_c[IDX_W'(k)];
            sum_hi_c    = sum_hi_c + (aligned_c[IDX_W'(k)] & ~LO_MASK);
            sum_lo_c    = sum_lo_c | (aligned_c[IDX_W'(k)] & LO_MASK);
        end
        sum_c = (s2_mode == MODE_EXACT) ? sum_exact_c : (sum_hi_c | sum_lo_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_mode   <= MODE_EXACT;
            s2_valid  <= 1'b0;
            s2_mode   <= MODE_EXACT;
            s2_pp     <= '0;
            out_valid <= 1'b0;
            r         <= '0;
            r_mode    <= 2'd0;
        end else if (en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a    <= a;
                s1_b    <= b;
                s1_mode <= mode_e'(mode);
            end
            s2_valid  <= s1_valid;
            if (s1_valid) begin
                s2_pp   <= pp_c;
                s2_mode <= s1_mode;
            end
            out_valid <= s2_valid;
            if (s2_valid) begin
                r      <= sum_c;
                r_mode <= s2_mode;
            end
        end
    end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Scoreboard bench for approx_mult_pipe at WIDTH=8 (directed) and WIDTH=16 (random).
module tb_approx_mult_pipe;

    localparam int unsigned TR  = 2;
    localparam int unsigned LOA = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  a8, b8;
    logic [1:0]  mode8, r_mode8;
    logic [15:0] r8;
    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] a16, b16;
    logic [1:0]  mode16, r_mode16;
    logic [31:0] r16;

    int checks = 0;
    int passes = 0;
    int recv8  = 0;
    int recv16 = 0;
    logic [63:0] exp_r8[$];
    logic [1:0]  exp_m8[$];
    logic [63:0] exp_r16[$];
    logic [1:0]  exp_m16[$];

    approx_mult_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .mode(mode8), .out_valid(out_valid8),
        .out_ready(out_ready8), .r(r8), .r_mode(r_mode8)
    );

    approx_mult_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .mode(mode16), .out_valid(out_valid16),
        .out_ready(out_ready16), .r(r16), .r_mode(r_mode16)
    );

    // Reference: low part as OR of the low LOA bits, high part as a sum of each term shifted down.
    function automatic logic [63:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] m);
        int p = w / 4;
        logic [63:0] ex = 0, hi = 0, lo = 0, al, res;
        logic [3:0] da, db;
        logic [7:0] pp;
        bit apx;
        int s;
        for (int i = 0; i < p; i++) begin
            for (int j = 0; j < p; j++) begin
                da = a[4*i +: 4];
                db = b[4*j +: 4];
                pp = {4'b0, da} * {4'b0, db};
                s  = i + j;
                case (m)
                    2'd0:    apx = 1'b0;
                    2'd1:    apx = (s != 0);
                    2'd2:    apx = 1'b1;
                    default: apx = (s < p / 2);
                endcase
                if (apx) pp = (pp >> TR) << TR;
                al = {56'b0, pp} << (4 * s);
                ex = ex + al;
                lo = lo | (al & ((64'd1 << LOA) - 64'd1));
                hi = hi + (al >> LOA);
            end
        end
        res = (m == 2'd0) ? ex : ((hi << LOA) | lo);
        return res & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor8();
        logic [63:0] er;
        logic [1:0]  em;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_r8.delete();
                exp_m8.delete();
            end else begin
                if (in_valid8 && in_ready8) begin
                    exp_r8.push_back(model(8, 32'(a8), 32'(b8), mode8));
                    exp_m8.push_back(mode8);
                end
                if (out_valid8 && out_ready8) begin
                    recv8++;
                    checks++;
                    if (exp_r8.size() == 0) begin
                        $display("FAIL sb8_unexpected got r=%h with no pending item", r8);
                    end else begin
                        er = exp_r8.pop_front();
                        em = exp_m8.pop_front();
                        if (r8 !== er[15:0] || r_mode8 !== em)
                            $display("FAIL sb8_result got r=%h mode=%0d want r=%h mode=%0d",
                                     r8, r_mode8, er[15:0], em);
                        else passes++;
                    end
                end
            end
        end
    endtask

    task automatic monitor16();
        logic [63:0] er;
        logic [1:0]  em;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_r16.delete();
                exp_m16.delete();
            end else begin
                if (in_valid16 && in_ready16) begin
                    exp_r16.push_back(model(16, 32'(a16), 32'(b16), mode16));
                    exp_m16.push_back(mode16);
                end
                if (out_valid16 && out_ready16) begin
                    recv16++;
                    checks++;
                    if (exp_r16.size() == 0) begin
                        $display("FAIL sb16_unexpected got r=%h with no pending item", r16);
                    end else begin
                        er = exp_r16.pop_front();
                        em = exp_m16.pop_front();
                        if (r16 !== er[31:0] || r_mode16 !== em)
                            $display("FAIL sb16_result got r=%h mode=%0d want r=%h mode=%0d",
                                     r16, r_mode16, er[31:0], em);
                        else passes++;
                    end
                end
            end
        end
    endtask

    // Drives one item into dut8 and reports accept-to-valid latency and the result seen.
    task automatic send8(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                         output int lat, output logic [15:0] rr, output logic [1:0] rm);
        int n = 0;
        mode8 = m; a8 = a; b8 = b; in_valid8 = 1'b1;
        while (!in_ready8 && n < 20) begin step(); n++; end
        step();
        in_valid8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 20) begin step(); lat++; end
        rr = r8;
        rm = r_mode8;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (out_valid8 !== 1'b0 || r8 !== 16'h0 || r_mode8 !== 2'd0)
            $display("FAIL reset_state8 got v=%b r=%h m=%0d want v=0 r=0 m=0", out_valid8, r8, r_mode8);
        else passes++;
        checks++;
        if (out_valid16 !== 1'b0 || r16 !== 32'h0)
            $display("FAIL reset_state16 got v=%b r=%h want v=0 r=0", out_valid16, r16);
        else passes++;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready8 !== 1'b1)
            $display("FAIL reset_in_ready got %b want 1", in_ready8);
        else passes++;
    endtask

    task automatic test_vectors();
        logic [1:0]  vm[5] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd1};
        logic [7:0]  va[5] = '{8'hFF, 8'hFF, 8'h0F, 8'h0F, 8'h13};
        logic [7:0]  vb[5] = '{8'hFF, 8'hFF, 8'h0F, 8'h0F, 8'h11};
        logic [15:0] ve[5] = '{16'hFE01, 16'hFCE0, 16'h00E1, 16'h00E0, 16'h0003};
        int lat;
        logic [15:0] rr;
        logic [1:0]  rm;
        for (int k = 0; k < 5; k++) begin
            send8(vm[k], va[k], vb[k], lat, rr, rm);
            checks++;
            if (lat !== 3)
                $display("FAIL vec%0d_latency got %0d want 3", k, lat);
            else passes++;
            checks++;
            if (rr !== ve[k] || rm !== vm[k])
                $display("FAIL vec%0d_result got r=%h m=%0d want r=%h m=%0d", k, rr, rm, ve[k], vm[k]);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        int start = recv8;
        int stall_cycles = 0;
        int n;
        logic [15:0] held = '0;
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    bit ok;
                    mode8 = 2'd0; a8 = 8'(8'h31 + 8'(k * 37)); b8 = 8'(8'hC7 - 8'(k * 19));
                    in_valid8 = 1'b1;
                    n = 0;
                    do begin
                        @(negedge clk);
                        ok = in_ready8;
                        step();
                        n++;
                    end while (!ok && n < 20);
                end
                in_valid8 = 1'b0;
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    out_ready8 = !(c >= 4 && c < 8);
                    @(negedge clk);
                    if (out_valid8 && !out_ready8) begin
                        stall_cycles++;
                        checks++;
                        if (in_ready8 !== 1'b0)
                            $display("FAIL stall_in_ready c=%0d got %b want 0", c, in_ready8);
                        else passes++;
                        if (c == 4) held = r8;
                        else begin
                            checks++;
                            if (r8 !== held)
                                $display("FAIL stall_hold c=%0d got r=%h want %h", c, r8, held);
                            else passes++;
                        end
                    end
                    step();
                end
            end
        join
        out_ready8 = 1'b1;
        n = 0;
        while (recv8 - start < 5 && n < 20) begin step(); n++; end
        checks++;
        if (stall_cycles !== 4)
            $display("FAIL stall_cycles got %0d want 4", stall_cycles);
        else passes++;
        checks++;
        if (recv8 - start !== 5 || exp_r8.size() !== 0)
            $display("FAIL b2b_count got %0d outputs (%0d pending) want 5 (0)",
                     recv8 - start, exp_r8.size());
        else passes++;
    endtask

    task automatic test_reset_midflight();
        int lat;
        logic [15:0] rr;
        logic [1:0]  rm;
        out_ready8 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mode8 = 2'd0; a8 = 8'(8'h50 + 8'(k)); b8 = 8'h77; in_valid8 = 1'b1;
            step();
        end
        in_valid8 = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready8 = 1'b1;
        checks++;
        if (out_valid8 !== 1'b0 || r8 !== 16'h0)
            $display("FAIL midreset_flush got v=%b r=%h want v=0 r=0", out_valid8, r8);
        else passes++;
        send8(2'd0, 8'hAB, 8'hCD, lat, rr, rm);
        checks++;
        if (lat !== 3 || rr !== 16'h88EF)
            $display("FAIL midreset_first got lat=%0d r=%h want lat=3 r=88ef", lat, rr);
        else passes++;
    endtask

    task automatic test_random16();
        int start = recv16;
        int timeouts = 0;
        int n;
        bit done = 1'b0;
        fork
            begin
                for (int m = 0; m < 4; m++) begin
                    for (int t = 0; t < 1000; t++) begin
                        bit ok;
                        a16 = 16'($urandom); b16 = 16'($urandom); mode16 = 2'(m);
                        in_valid16 = 1'b1;
                        n = 0;
                        do begin
                            @(negedge clk);
                            ok = in_ready16;
                            step();
                            n++;
                        end while (!ok && n < 50);
                        if (!ok) timeouts++;
                    end
                end
                in_valid16 = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready16 = 1'($urandom_range(0, 1));
                    step();
                end
                out_ready16 = 1'b1;
            end
        join
        n = 0;
        while (recv16 - start < 4000 && n < 100) begin step(); n++; end
        checks++;
        if (timeouts !== 0 || recv16 - start !== 4000 || exp_r16.size() !== 0)
            $display("FAIL rand16_count got %0d outputs, %0d timeouts, %0d pending want 4000, 0, 0",
                     recv16 - start, timeouts, exp_r16.size());
        else passes++;
    endtask

    initial begin
        rst = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; mode8 = '0; out_ready8 = 1'b1;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; mode16 = '0; out_ready16 = 1'b1;
        fork
            monitor8();
            monitor16();
        join_none
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_midflight();
        test_random16();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
